// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: register-address width, ALU op encodings
// and the control bundle carried from ID into EX.
package mips_pkg;

    localparam int REG_W   = 5;
    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
    } ctrl_t;

    // A bubble does nothing architecturally visible.
    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/id_hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the instruction in ID.
// Register 0 never hazards since its reads are forced to zero.
module id_hazard_detect
    import mips_pkg::*;
(
    input  logic             valid_ex,
    input  logic             mem_read_ex,
    input  logic [REG_W-1:0] write_register_ex,
    input  logic             valid_id,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             uses_rt,
    output logic             hazard
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (write_register_ex == rs);
        rt_match = uses_rt && (write_register_ex == rt);
        hazard   = valid_ex && mem_read_ex && (write_register_ex != '0)
                   && (rs_match || rt_match) && valid_id;
    end

endmodule

// File: rtl/id_ex_pipeline.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating count of inserted load-use bubbles.
module id_ex_pipeline
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Valid_ID,
    input  logic [REG_W-1:0]   Read_Address_1_ID,
    input  logic [REG_W-1:0]   Read_Address_2_ID,
    input  logic               Uses_Rt_ID,
    input  logic [REG_W-1:0]   Write_Register_ID,
    input  logic [DATA_W-1:0]  Read_Data_1_ID,
    input  logic [DATA_W-1:0]  Read_Data_2_ID,
    input  logic [DATA_W-1:0]  Sign_Extend_ID,
    input  logic [DATA_W-1:0]  PC_Plus4_ID,
    input  logic               RegWrite_ID,
    input  logic               MemRead_ID,
    input  logic               MemWrite_ID,
    input  logic               MemtoReg_ID,
    input  logic               ALUSrc_ID,
    input  logic [ALUOP_W-1:0] ALUOp_ID,
    input  logic               Flush_EX,
    input  logic               Hold_EX,
    output logic               Stall_ID,
    output logic               Valid_EX,
    output logic [REG_W-1:0]   Read_Address_1_EX,
    output logic [REG_W-1:0]   Read_Address_2_EX,
    output logic               Uses_Rt_EX,
    output logic [REG_W-1:0]   Write_Register_EX,
    output logic [DATA_W-1:0]  Read_Data_1_EX,
    output logic [DATA_W-1:0]  Read_Data_2_EX,
    output logic [DATA_W-1:0]  Sign_Extend_EX,
    output logic [DATA_W-1:0]  PC_Plus4_EX,
    output logic               RegWrite_EX,
    output logic               MemRead_EX,
    output logic               MemWrite_EX,
    output logic               MemtoReg_EX,
    output logic               ALUSrc_EX,
    output logic [ALUOP_W-1:0] ALUOp_EX,
    output logic [CNT_W-1:0]   Stall_Count
);

    ctrl_t ctrl_id;
    ctrl_t ctrl_ex;
    logic  hazard;

    always_comb begin
        ctrl_id            = BUBBLE;
        ctrl_id.reg_write  = RegWrite_ID;
        ctrl_id.mem_read   = MemRead_ID;
        ctrl_id.mem_write  = MemWrite_ID;
        ctrl_id.mem_to_reg = MemtoReg_ID;
        ctrl_id.alu_src    = ALUSrc_ID;
        ctrl_id.alu_op     = ALUOp_ID;
    end

    id_hazard_detect u_hazard (
        .valid_ex          (Valid_EX),
        .mem_read_ex       (ctrl_ex.mem_read),
        .write_register_ex (Write_Register_EX),
        .valid_id          (Valid_ID),
        .rs                (Read_Address_1_ID),
        .rt                (Read_Address_2_ID),
        .uses_rt           (Uses_Rt_ID),
        .hazard            (hazard)
    );

    assign Stall_ID = hazard | Hold_EX;

    // Bubbles only clear valid/control; data fields keep their old values.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Valid_EX          <= 1'b0;
            ctrl_ex           <= BUBBLE;
            Read_Address_1_EX <= '0;
            Read_Address_2_EX <= '0;
            Uses_Rt_EX        <= 1'b0;
            Write_Register_EX <= '0;
            Read_Data_1_EX    <= '0;
            Read_Data_2_EX    <= '0;
            Sign_Extend_EX    <= '0;
            PC_Plus4_EX       <= '0;
            Stall_Count       <= '0;
        end else if (Flush_EX) begin
            Valid_EX <= 1'b0;
            ctrl_ex  <= BUBBLE;
        end else if (!Hold_EX) begin
            if (hazard) begin
                Valid_EX <= 1'b0;
                ctrl_ex  <= BUBBLE;
                if (Stall_Count != '1)
                    Stall_Count <= Stall_Count + 1'b1;
            end else begin
                Valid_EX          <= Valid_ID;
                ctrl_ex           <= Valid_ID ? ctrl_id : BUBBLE;
                Read_Address_1_EX <= Read_Address_1_ID;
                Read_Address_2_EX <= Read_Address_2_ID;
                Uses_Rt_EX        <= Uses_Rt_ID;
                Write_Register_EX <= Write_Register_ID;
                Read_Data_1_EX    <= Read_Data_1_ID;
                Read_Data_2_EX    <= Read_Data_2_ID;
                Sign_Extend_EX    <= Sign_Extend_ID;
                PC_Plus4_EX       <= PC_Plus4_ID;
            end
        end
    end

    assign RegWrite_EX = ctrl_ex.reg_write;
    assign MemRead_EX  = ctrl_ex.mem_read;
    assign MemWrite_EX = ctrl_ex.mem_write;
    assign MemtoReg_EX = ctrl_ex.mem_to_reg;
    assign ALUSrc_EX   = ctrl_ex.alu_src;
    assign ALUOp_EX    = ctrl_ex.alu_op;

endmodule

// File: doc/id_ex_pipeline.md
ID_EX_PIPELINE -- requirements
Module: ID_EX_Pipeline

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath width of register, immediate and PC fields.
REQ-002 SHALL have parameter CNT_W, 16, width of the load-use stall counter.
REQ-003 SHALL have one clock; reset is synchronous and active-high; ports named Clk and Rst.
REQ-004 SHALL have ports, clock and reset first:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- Valid_ID  in  1  ID holds a real instruction
- Read_Address_1_ID  in  5  rs
- Read_Address_2_ID  in  5  rt
- Uses_Rt_ID  in  1  instruction reads rt as a source
- Write_Register_ID  in  5  destination register
- Read_Data_1_ID, Read_Data_2_ID  in  DATA_W  register-file read data
- Sign_Extend_ID  in  DATA_W  immediate
- PC_Plus4_ID  in  DATA_W  PC+4
- RegWrite_ID, MemRead_ID, MemWrite_ID, MemtoReg_ID, ALUSrc_ID  in  1 each  controls
- ALUOp_ID  in  4  ALU operation
- Flush_EX  in  1  taken branch/jump; kill instruction entering EX
- Hold_EX  in  1  downstream busy; freeze EX
- Stall_ID  out  1  freeze PC and IF/ID this cycle
- Valid_EX, all *_EX  out  same widths  registered copies of every *_ID input
- Stall_Count  out  CNT_W  saturating count of inserted load-use bubbles

Function
REQ-005 SHALL compute Hazard = Valid_EX & MemRead_EX & (Write_Register_EX != 0) & ((Write_Register_EX == Read_Address_1_ID) | (Uses_Rt_ID & Write_Register_EX == Read_Address_2_ID)) & Valid_ID.
REQ-006 SHALL drive Stall_ID = Hazard | Hold_EX combinationally, same cycle, no register.
REQ-007 SHALL resolve each rising edge by priority: Rst > Flush_EX > Hold_EX > Hazard > normal load.
REQ-008 Flush_EX: SHALL load a bubble: Valid_EX=0, RegWrite/MemRead/MemWrite/MemtoReg/ALUSrc_EX=0, ALUOp_EX=0; data/address fields hold previous values.
REQ-009 Hold_EX (no flush): SHALL keep every *_EX output unchanged, including Valid_EX; no bubble inserted, Stall_Count unchanged.
REQ-010 Hazard (no flush/hold): SHALL load a bubble per REQ-008 and increment Stall_Count by 1, saturating at all-ones.
REQ-011 Normal load: SHALL capture every *_ID input into its *_EX register, Valid_EX = Valid_ID; latency exactly 1 cycle.
REQ-012 Valid_ID=0 on normal load: SHALL clear all control outputs as in REQ-008 (no side effect from invalid slots).
REQ-013 SHALL insert exactly one bubble per load-use pair: bubble clears Valid_EX, so Hazard deasserts the following cycle.
REQ-014 SHALL treat register 0 as never hazardous (matches register file forcing $0 reads to zero).
REQ-015 Flush_EX with Hazard: SHALL load the bubble but SHALL NOT increment Stall_Count.

Reset
REQ-016 On Rst at rising edge: Valid_EX=0, every control and data *_EX output 0, Stall_Count=0; Stall_ID = Hold_EX during reset since Valid_EX=0 afterwards.
REQ-017 Rst mid-hold or mid-hazard SHALL override all other inputs; first post-reset cycle behaves as pipeline empty.

Structure
REQ-018 Shared package mips_pkg SHALL hold ALUOp width/encodings, register-address width (5) and a control-bundle typedef (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, ALUOp) with its BUBBLE constant (all zero).
REQ-019 Hazard compare SHALL be a combinational sub-module ID_Hazard_Detect; registers and counter stay in ID_EX_Pipeline.

Verification
REQ-020 lw $5 then add $6,$5,$7 back to back -> Stall_ID=1 one cycle, one bubble (Valid_EX=0, RegWrite_EX=0), add reaches EX next cycle, Stall_Count=1.
REQ-021 lw $0 then add $6,$0,$7 -> Stall_ID=0, no bubble, Stall_Count=0.
REQ-022 lw $5 then sw using $5 only as rt with Uses_Rt_ID=1 -> one bubble; same with Uses_Rt_ID=0 -> none.
REQ-023 Hold_EX high 3 cycles with Read_Data_1_ID=0xDEADBEEF changing to 0x1 -> *_EX frozen 3 cycles, Stall_ID=1, then 0x1 loads.
REQ-024 Flush_EX and Hazard same cycle -> bubble, Stall_Count unchanged; Flush_EX and Hold_EX same cycle -> bubble.
REQ-025 Preload Stall_Count near all-ones, force 2 hazards -> saturates at 0xFFFF; Rst mid-stall -> all outputs 0 next cycle.
